// File: rtl/tick_gen_pkg.sv
// Shared constants and types for the multi-channel tick generator.
// Period constants assume a 25 MHz system clock.
package tick_gen_pkg;

  localparam logic [31:0] DEFAULT_DIV_0P5S = 32'd12500000;
  localparam logic [31:0] DIV_1S           = 32'd25000000;
  localparam logic [31:0] DIV_10S          = 32'd250000000;

  // Per-channel run state: ARMED counts when enabled, DONE parks a finished one-shot.
  typedef enum logic [0:0] {
    CH_ARMED = 1'b0,
    CH_DONE  = 1'b1
  } ch_state_t;

  // Single-bit per-channel state that travels together through the next-state logic.
  typedef struct packed {
    logic pend_valid;
    logic tick;
    logic clk_out;
  } ch_flags_t;

endpackage

// File: rtl/tick_gen_mc_if.sv
// Control/status bundle between a tick generator and its host.
// The host drives enables, modes, sync and period writes; the generator returns ticks, clocks and done flags.
interface tick_gen_mc_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 32
);

  logic [CHANNELS-1:0] en;
  logic [CHANNELS-1:0] oneshot;
  logic                sync;
  logic [CHANNELS-1:0] div_wr;
  logic [WIDTH-1:0]    div_din;
  logic [CHANNELS-1:0] tick_out;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] done;

  modport master (
    output en,
    output oneshot,
    output sync,
    output div_wr,
    output div_din,
    input  tick_out,
    input  clk_out,
    input  done
  );

  modport slave (
    input  en,
    input  oneshot,
    input  sync,
    input  div_wr,
    input  div_din,
    output tick_out,
    output clk_out,
    output done
  );

endinterface

// File: rtl/tick_channel.sv
// One tick generator channel: programmable period, periodic or one-shot, with a
// shadowed period register so a live write never truncates the running period.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEFAULT_DIV_0P5S)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             oneshot,
  input  logic             sync,
  input  logic             div_wr,
  input  logic [WIDTH-1:0] div_din,
  output logic             tick_out,
  output logic             clk_out,
  output logic             done
);

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_s;
  logic [WIDTH-1:0] per_r;
  logic [WIDTH-1:0] per_s;
  logic [WIDTH-1:0] shadow_r;
  logic [WIDTH-1:0] shadow_s;
  logic [WIDTH-1:0] last_s;
  logic             wrap_s;
  ch_flags_t        flags_r;
  ch_flags_t        flags_s;
  ch_state_t        state_r;
  ch_state_t        state_s;

  // Terminal count; a programmed period of 0 behaves as 1 so cnt never runs away.
  always_comb begin
    last_s = (per_r == {WIDTH{1'b0}}) ? {WIDTH{1'b0}} : (per_r - WIDTH'(1));
    wrap_s = (cnt_r == last_s);
  end

  // Next-state logic: sync beats disable beats done beats wrap; period writes are layered last.
  always_comb begin
    cnt_s         = cnt_r;
    per_s         = per_r;
    shadow_s      = shadow_r;
    flags_s       = flags_r;
    flags_s.tick  = 1'b0;
    state_s       = state_r;

    if (sync) begin
      cnt_s              = {WIDTH{1'b0}};
      flags_s.clk_out    = 1'b0;
      per_s              = flags_r.pend_valid ? shadow_r : per_r;
      flags_s.pend_valid = 1'b0;
    end else if (!en) begin
      cnt_s              = {WIDTH{1'b0}};
      per_s              = flags_r.pend_valid ? shadow_r : per_r;
      flags_s.pend_valid = 1'b0;
    end else if (state_r == CH_DONE) begin
      cnt_s = {WIDTH{1'b0}};
    end else if (wrap_s) begin
      cnt_s              = {WIDTH{1'b0}};
      flags_s.tick       = 1'b1;
      flags_s.clk_out    = ~flags_r.clk_out;
      per_s              = flags_r.pend_valid ? shadow_r : per_r;
      flags_s.pend_valid = 1'b0;
      state_s            = oneshot ? CH_DONE : CH_ARMED;
    end else begin
      cnt_s = cnt_r + WIDTH'(1);
    end

    // Dropping en is the only way to re-arm a finished one-shot.
    state_s = en ? state_s : CH_ARMED;

    // A write while running lands in the shadow; the pending flag read above is the old one,
    // so a write coincident with a wrap waits for the following wrap.
    case ({div_wr, en})
      2'b10: begin
        per_s              = div_din;
        flags_s.pend_valid = 1'b0;
      end
      2'b11: begin
        shadow_s           = div_din;
        flags_s.pend_valid = 1'b1;
      end
      default: begin
        shadow_s = shadow_s;
      end
    endcase
  end

  // Channel state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r    <= {WIDTH{1'b0}};
      per_r    <= DEFAULT_DIV;
      shadow_r <= {WIDTH{1'b0}};
      flags_r  <= '{pend_valid: 1'b0, tick: 1'b0, clk_out: 1'b0};
      state_r  <= CH_ARMED;
    end else begin
      cnt_r    <= cnt_s;
      per_r    <= per_s;
      shadow_r <= shadow_s;
      flags_r  <= flags_s;
      state_r  <= state_s;
    end
  end

  assign tick_out = flags_r.tick;
  assign clk_out  = flags_r.clk_out;
  assign done     = (state_r == CH_DONE);

endmodule

// File: rtl/tick_gen_mc.sv
// Multi-channel tick/clock generator: independent channels sharing one period data bus and
// one phase-sync pulse. tick_out is a clock enable for logic in the clk domain.
module tick_gen_mc
  import tick_gen_pkg::*;
#(
  parameter int               CHANNELS    = 2,
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEFAULT_DIV_0P5S)
) (
  input  logic          clk,
  input  logic          reset,
  tick_gen_mc_if.slave  bus
);

  logic [CHANNELS-1:0] tick_s;
  logic [CHANNELS-1:0] clk_s;
  logic [CHANNELS-1:0] done_s;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    tick_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en       (bus.en[i]),
      .oneshot  (bus.oneshot[i]),
      .sync     (bus.sync),
      .div_wr   (bus.div_wr[i]),
      .div_din  (bus.div_din),
      .tick_out (tick_s[i]),
      .clk_out  (clk_s[i]),
      .done     (done_s[i])
    );
  end

  assign bus.tick_out = tick_s;
  assign bus.clk_out  = clk_s;
  assign bus.done     = done_s;

endmodule

// File: tb/tb_tick_gen_mc.sv
// Directed bench for tick_gen_mc with DEFAULT_DIV shrunk to 5; expected tick cycles are hand-derived.
module tb_tick_gen_mc;

  localparam int CH = 2;
  localparam int W  = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  tick_gen_mc_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  tick_gen_mc #(
    .CHANNELS    (CH),
    .WIDTH       (W),
    .DEFAULT_DIV (32'd5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.en      = 2'b00;
    bus.oneshot = 2'b00;
    bus.sync    = 1'b0;
    bus.div_wr  = 2'b00;
    bus.div_din = 32'd0;

    // reset state
    #12;
    check_val("rst_tick", 32'(bus.tick_out), 32'd0);
    check_val("rst_clk",  32'(bus.clk_out),  32'd0);
    check_val("rst_done", 32'(bus.done),     32'd0);
    reset = 1'b1;

    // default period 5, periodic
    bus.en = 2'b01;
    for (int c = 1; c <= 15; c++) begin
      step();
      check_val($sformatf("t1_tick c%0d", c), 32'(bus.tick_out), {31'd0, (c % 5 == 0)});
      check_val($sformatf("t1_clk c%0d", c),  32'(bus.clk_out),  {31'd0, ((c / 5) % 2 == 1)});
    end
    check_val("t1_done", 32'(bus.done), 32'd0);

    // disable holds clk_out, then program P=4 while idle
    bus.en = 2'b00;
    step();
    check_val("dis_clk_hold", 32'(bus.clk_out),  32'd1);
    check_val("dis_tick",     32'(bus.tick_out), 32'd0);
    bus.div_wr  = 2'b01;
    bus.div_din = 32'd4;
    step();
    bus.div_wr = 2'b00;

    // live change: write 7 mid-period, then 3 on a wrap cycle
    bus.en = 2'b01;
    for (int c = 1; c <= 36; c++) begin
      bus.div_wr  = (c == 6 || c == 22) ? 2'b01 : 2'b00;
      bus.div_din = (c == 6) ? 32'd7 : 32'd3;
      step();
      check_val($sformatf("t2_tick c%0d", c), 32'(bus.tick_out),
                {31'd0, (c == 4 || c == 8 || c == 15 || c == 22 || c == 29 || c == 32 || c == 35)});
    end
    bus.div_wr = 2'b00;

    // P=0 on ch0, P=1 on ch1; sync while idle clears clk_out
    bus.en      = 2'b00;
    bus.div_wr  = 2'b01;
    bus.div_din = 32'd0;
    step();
    bus.div_wr  = 2'b10;
    bus.div_din = 32'd1;
    bus.sync    = 1'b1;
    step();
    bus.div_wr = 2'b00;
    bus.sync   = 1'b0;
    check_val("t3_sync_clk", 32'(bus.clk_out), 32'd0);
    bus.en = 2'b11;
    for (int c = 1; c <= 6; c++) begin
      step();
      check_val($sformatf("t3_tick c%0d", c), 32'(bus.tick_out), 32'd3);
      check_val($sformatf("t3_clk c%0d", c),  32'(bus.clk_out),  (c % 2 == 1) ? 32'd3 : 32'd0);
    end

    // one-shot, P=3
    bus.en      = 2'b00;
    bus.div_wr  = 2'b01;
    bus.div_din = 32'd3;
    step();
    bus.div_wr  = 2'b00;
    bus.oneshot = 2'b01;
    bus.en      = 2'b01;
    for (int c = 1; c <= 23; c++) begin
      step();
      check_val($sformatf("t4_tick c%0d", c), 32'(bus.tick_out), {31'd0, (c == 3)});
      check_val($sformatf("t4_done c%0d", c), 32'(bus.done),     {31'd0, (c >= 3)});
    end
    bus.en = 2'b00;
    step();
    check_val("t4_rearm_done", 32'(bus.done), 32'd0);
    bus.en = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_val($sformatf("t4b_tick c%0d", c), 32'(bus.tick_out), {31'd0, (c == 3)});
      check_val($sformatf("t4b_done c%0d", c), 32'(bus.done),     {31'd0, (c >= 3)});
    end
    bus.en      = 2'b00;
    bus.oneshot = 2'b00;
    step();

    // sync on a ch0 wrap: ch0 P=4, ch1 P=6
    bus.div_wr  = 2'b01;
    bus.div_din = 32'd4;
    step();
    bus.div_wr  = 2'b10;
    bus.div_din = 32'd6;
    step();
    bus.div_wr = 2'b00;
    bus.en     = 2'b11;
    for (int c = 1; c <= 16; c++) begin
      bus.sync = (c == 8);
      step();
      bus.sync = 1'b0;
      check_val($sformatf("t5_tick c%0d", c), 32'(bus.tick_out),
                {30'd0, (c == 6 || c == 14), (c == 4 || c == 12 || c == 16)});
      if (c >= 8) begin
        check_val($sformatf("t5_clk c%0d", c), 32'(bus.clk_out),
                  {30'd0, (c >= 14), (c >= 12 && c < 16)});
      end
    end

    // async reset with a pending write on ch0
    bus.div_wr  = 2'b01;
    bus.div_din = 32'd9;
    step();
    bus.div_wr = 2'b00;
    check_val("t6_pre_clk", 32'(bus.clk_out), 32'd2);
    #3;
    reset = 1'b0;
    #1;
    check_val("t6_rst_tick", 32'(bus.tick_out), 32'd0);
    check_val("t6_rst_clk",  32'(bus.clk_out),  32'd0);
    check_val("t6_rst_done", 32'(bus.done),     32'd0);
    bus.en = 2'b00;
    @(posedge clk);
    #2;
    reset  = 1'b1;
    bus.en = 2'b01;
    for (int c = 1; c <= 10; c++) begin
      step();
      check_val($sformatf("t6_tick c%0d", c), 32'(bus.tick_out), {31'd0, (c % 5 == 0)});
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
